// File: rtl/mult_wallace_pipe.sv
// rtl/mult_wallace_pipe.sv - pipelined Wallace-tree multiplier with valid/ready handshake
// Optional feature macro: MULT_WALLACE_TAG_EN (adds in_tag/out_tag sideband carried with each product)
module mult_wallace_pipe #(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int STAGES = 3,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] product
`ifdef MULT_WALLACE_TAG_EN
  ,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag
`endif
);

  localparam int P  = A_W + B_W;
  // One row per multiplier bit plus one row for the Baugh-Wooley correction constant
  // (that row stays zero in unsigned mode).
  localparam int NR = B_W + 1;
  localparam logic [P-1:0] ONE = 1;
  localparam logic [P-1:0] BW_CONST = (ONE << (A_W - 1)) + (ONE << (B_W - 1)) + (ONE << (P - 1));

  typedef logic [NR-1:0][P-1:0] rows_t;

  // Number of 3:2 levels needed to bring n rows down to two.
  function automatic int calc_nlev(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    for (int i = 0; i < 16; i++) begin
      if (c > 2) begin
        c = 2 * (c / 3) + c % 3;
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int NLEV = calc_nlev(NR);
  // Number of stages sharing the reduction levels; the last stage is reserved for the CPA.
  localparam int R = (STAGES > 1) ? STAGES - 1 : 1;

  // First reduction level handled by reduction stage s; levels spread as evenly as possible.
  function automatic int lv_lo(input int s);
    return (s * NLEV) / R;
  endfunction

  // Partial-product array; in signed mode the mixed sign terms are inverted and the
  // correction constant supplies the missing weights (modified Baugh-Wooley).
  function automatic rows_t gen_pp(input logic [A_W-1:0] x, input logic [B_W-1:0] y);
    rows_t r;
    logic [P-1:0] row;
    r = '0;
    for (int i = 0; i < B_W; i++) begin
      row = '0;
      for (int j = 0; j < A_W; j++) begin
        row[i+j] = x[j] & y[i];
        if (SIGNED != 0 && ((i == B_W - 1) != (j == A_W - 1)))
          row[i+j] = ~row[i+j];
      end
      r[i] = row;
    end
    if (SIGNED != 0)
      r[NR-1] = BW_CONST;
    return r;
  endfunction

  // One carry-save level: each group of three rows becomes sum + shifted carry, leftovers pass.
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int g;
    o = '0;
    g = n / 3;
    for (int k = 0; k < NR / 3; k++) begin
      if (k < g) begin
        o[2*k]   = r[3*k] ^ r[3*k+1] ^ r[3*k+2];
        o[2*k+1] = ((r[3*k] & r[3*k+1]) | (r[3*k] & r[3*k+2]) | (r[3*k+1] & r[3*k+2])) << 1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (k < n % 3)
        o[2*g+k] = r[3*g+k];
    end
    return o;
  endfunction

  // Apply tree levels [lo, hi) to a row set that entered the tree at level 0.
  function automatic rows_t reduce(input rows_t r, input int lo, input int hi);
    rows_t t;
    int n;
    t = r;
    n = NR;
    for (int l = 0; l < 16; l++) begin
      if (l >= lo && l < hi)
        t = csa_level(t, n);
      if (n > 2)
        n = 2 * (n / 3) + n % 3;
    end
    return t;
  endfunction

  // Final carry-propagate add of the two surviving rows.
  function automatic logic [P-1:0] cpa(input rows_t r);
    return r[0] + r[1];
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] en;

  // Load enables ripple back from the consumer; data registers only load real items.
  always_comb begin
    logic chain;
    chain = out_ready;
    ld = '0;
    en = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain = !v[k] || chain;
      ld[k] = chain;
    end
    en[0] = ld[0] & in_valid;
    for (int k = 1; k < STAGES; k++)
      en[k] = ld[k] & v[k-1];
  end

  assign in_ready  = ld[0];
  assign out_valid = v[STAGES-1];

  // Valid shift chain; a loading stage takes its upstream valid, so bubbles compress.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else begin
      if (ld[0])
        v[0] <= in_valid;
      for (int k = 1; k < STAGES; k++)
        if (ld[k])
          v[k] <= v[k-1];
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      // Whole tree plus CPA ahead of the only register.
      always_ff @(posedge clk) begin
        if (rst)
          product <= '0;
        else if (en[0])
          product <= cpa(reduce(gen_pp(a, b), 0, NLEV));
      end
    end else begin : g_multi
      rows_t sr [STAGES-1];

      // Reduction stages: partial products in the first, tree levels spread over all of them.
      always_ff @(posedge clk) begin
        if (en[0])
          sr[0] <= reduce(gen_pp(a, b), lv_lo(0), lv_lo(1));
        for (int k = 1; k < STAGES - 1; k++)
          if (en[k])
            sr[k] <= reduce(sr[k-1], lv_lo(k), lv_lo(k + 1));
      end

      // Last stage: carry-propagate add into the product register.
      always_ff @(posedge clk) begin
        if (rst)
          product <= '0;
        else if (en[STAGES-1])
          product <= cpa(sr[STAGES-2]);
      end
    end
  endgenerate

`ifdef MULT_WALLACE_TAG_EN
  logic [TAG_W-1:0] tq [STAGES];

  // Tag rides alongside its operands under the same enables as the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++)
        tq[k] <= '0;
    end else begin
      if (en[0])
        tq[0] <= in_tag;
      for (int k = 1; k < STAGES; k++)
        if (en[k])
          tq[k] <= tq[k-1];
    end
  end

  assign out_tag = tq[STAGES-1];
`endif

endmodule

// File: tb/tb_mult_wallace_pipe.sv
// tb/tb_mult_wallace_pipe.sv - directed self-checking bench for mult_wallace_pipe
module tb_mult_wallace_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // u0 (unsigned 16x16, 3 stages) and u1 (signed 16x16, 3 stages) share their inputs
  logic        iv = 1'b0;
  logic        ordy = 1'b1;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ir0, ov0, ir1, ov1;
  logic [31:0] p0, p1;

  // u2: unsigned 8x12, 1 stage
  logic        iv2 = 1'b0, or2 = 1'b1, ir2, ov2;
  logic [7:0]  a2 = '0;
  logic [11:0] b2 = '0;
  logic [19:0] p2;

  // u3: signed 32x32, 6 stages
  logic        iv3 = 1'b0, or3 = 1'b1, ir3, ov3;
  logic [31:0] a3 = '0, b3 = '0;
  logic [63:0] p3;

`ifdef MULT_WALLACE_TAG_EN
  logic [3:0] tag0 = '0;
  logic [3:0] ot0, ot1, ot2, ot3;
`endif

  mult_wallace_pipe #(.A_W(16), .B_W(16), .STAGES(3), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir0), .a(a16), .b(b16),
    .out_valid(ov0), .out_ready(ordy), .product(p0)
`ifdef MULT_WALLACE_TAG_EN
    , .in_tag(tag0), .out_tag(ot0)
`endif
  );

  mult_wallace_pipe #(.A_W(16), .B_W(16), .STAGES(3), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir1), .a(a16), .b(b16),
    .out_valid(ov1), .out_ready(ordy), .product(p1)
`ifdef MULT_WALLACE_TAG_EN
    , .in_tag(4'h0), .out_tag(ot1)
`endif
  );

  mult_wallace_pipe #(.A_W(8), .B_W(12), .STAGES(1), .SIGNED(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .product(p2)
`ifdef MULT_WALLACE_TAG_EN
    , .in_tag(4'h0), .out_tag(ot2)
`endif
  );

  mult_wallace_pipe #(.A_W(32), .B_W(32), .STAGES(6), .SIGNED(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .out_valid(ov3), .out_ready(or3), .product(p3)
`ifdef MULT_WALLACE_TAG_EN
    , .in_tag(4'h0), .out_tag(ot3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One operand pair into u0/u1 with out_ready high; checks latency and both products.
  task automatic op16(input logic [15:0] x, input logic [15:0] y,
                      input logic [31:0] eu, input logic [31:0] es, input string tag);
    int lat;
    @(negedge clk);
    iv = 1'b1; a16 = x; b16 = y; ordy = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(ir0), 64'(1));
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    #1;
    lat = 1;
    while (!ov0 && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(3));
    chk({tag, "_unsigned"}, 64'(p0), 64'(eu));
    chk({tag, "_signed"}, 64'(p1), 64'(es));
    @(negedge clk);
    #1;
    chk({tag, "_single"}, 64'(ov0), 64'(0));
  endtask

  initial begin
    int idx, acc, got, bad, snd2, rcv2, snd3, rcv3;
    logic [19:0] q2 [$];
    logic [63:0] q3 [$];
    logic [63:0] e;
    longint sa, sb;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid0", 64'(ov0), 64'(0));
    chk("rst_product0", 64'(p0), 64'(0));
    chk("rst_in_ready0", 64'(ir0), 64'(1));
    chk("rst_product1", 64'(p1), 64'(0));
    chk("rst_product3", p3, 64'(0));
`ifdef MULT_WALLACE_TAG_EN
    chk("rst_out_tag", 64'(ot0), 64'(0));
`endif

    // directed products, unsigned and signed side by side
    op16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h00000001, "ffff_ffff");
    op16(16'h0000, 16'h1234, 32'h00000000, 32'h00000000, "zero");
    op16(16'h8000, 16'h8000, 32'h40000000, 32'h40000000, "min_min");
    op16(16'hFFFF, 16'h0001, 32'h0000FFFF, 32'hFFFFFFFF, "neg1_one");
    op16(16'h7FFF, 16'h8000, 32'h3FFF8000, 32'hC0008000, "max_min");

    // backpressure: fill with out_ready low
    ordy = 1'b0; idx = 1; acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      iv = (idx <= 5); a16 = 16'(idx); b16 = 16'd3;
      #1;
      if (iv && ir0) begin idx++; acc++; end
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("bp_accepts", 64'(acc), 64'(3));
    chk("bp_in_ready_low", 64'(ir0), 64'(0));
    chk("bp_out_valid", 64'(ov0), 64'(1));
    chk("bp_hold_a", 64'(p0), 64'(3));
    @(negedge clk);
    #1;
    chk("bp_hold_b", 64'(p0), 64'(3));
    chk("bp_hold_signed", 64'(p1), 64'(3));

    // release and drain in order
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      ordy = 1'b1; iv = (idx <= 5); a16 = 16'(idx); b16 = 16'd3;
      #1;
      if (ov0) begin
        chk("bp_drain", 64'(p0), 64'(3 * (got + 1)));
        got++;
      end
      if (iv && ir0) idx++;
      @(posedge clk);
    end
    chk("bp_drain_count", 64'(got), 64'(5));
    @(negedge clk);
    iv = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (ov0) bad++;
    end
    chk("bp_no_duplicates", 64'(bad), 64'(0));

    // reset mid-stream
    @(negedge clk); iv = 1'b1; a16 = 16'd100; b16 = 16'd100;
    @(negedge clk); a16 = 16'd200; b16 = 16'd2;
    @(negedge clk); iv = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(ir0), 64'(1));
    bad = 0;
    repeat (6) begin
      if (ov0 || p0 != 32'd0) bad++;
      @(negedge clk);
      #1;
    end
    chk("mid_rst_no_stale", 64'(bad), 64'(0));
    op16(16'd7, 16'd6, 32'd42, 32'd42, "after_rst");

    // random streams on the 8x12/1-stage and 32x32-signed/6-stage instances
    snd2 = 0; rcv2 = 0; snd3 = 0; rcv3 = 0;
    for (int c = 0; c < 4000 && (rcv2 < 300 || rcv3 < 300); c++) begin
      @(negedge clk);
      iv2 = (snd2 < 300) && ($urandom_range(0, 3) != 0);
      a2 = 8'($urandom); b2 = 12'($urandom); or2 = ($urandom_range(0, 3) != 0);
      iv3 = (snd3 < 300) && ($urandom_range(0, 3) != 0);
      a3 = $urandom; b3 = $urandom; or3 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov2 && or2) begin
        e = (q2.size() > 0) ? 64'(q2.pop_front()) : 64'hDEAD;
        chk("rand_8x12", 64'(p2), e);
        rcv2++;
      end
      if (iv2 && ir2) begin q2.push_back(20'(a2) * 20'(b2)); snd2++; end
      if (ov3 && or3) begin
        e = (q3.size() > 0) ? q3.pop_front() : 64'hDEAD;
        chk("rand_32x32s", p3, e);
        rcv3++;
      end
      if (iv3 && ir3) begin
        sa = longint'($signed(a3)); sb = longint'($signed(b3));
        q3.push_back(64'(sa * sb));
        snd3++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    iv2 = 1'b0; iv3 = 1'b0;
    chk("rand_8x12_count", 64'(rcv2), 64'(300));
    chk("rand_32x32s_count", 64'(rcv3), 64'(300));

`ifdef MULT_WALLACE_TAG_EN
    // tags travel with their own products under random backpressure
    idx = 0; got = 0;
    for (int c = 0; c < 80 && got < 3; c++) begin
      @(negedge clk);
      iv = (idx < 3); a16 = 16'(11 + idx); b16 = 16'd1; tag0 = 4'(idx + 1);
      ordy = ($urandom_range(0, 1) != 0);
      #1;
      if (ov0) chk("tag_align", 64'(ot0), 64'(p0 - 32'd10));
      if (ov0 && ordy) got++;
      if (iv && ir0) idx++;
      @(posedge clk);
    end
    chk("tag_count", 64'(got), 64'(3));
    @(negedge clk); iv = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("tag_after_rst", 64'(ot0), 64'(0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
